imu_sample_scheduler: RTL and testbench

- Sequences one coherent IMU sample per period: triggers an ADC channel sweep (depth, gyro X/Y/Z), then a magnetometer I2C read, then latches all seven values into one snapshot with a sample_valid pulse.
- Sits between the ADC controller / magnetometer I2C interface and the gyro integrator / bus-facing registers.
- Detects late or missing sensor completions and counts dropped periods.

---
 rtl/imu_pkg.sv | 25 ++
 rtl/imu_period_timer.sv | 30 +++
 rtl/imu_sample_scheduler.sv | 167 ++++++++++++++++
 tb/tb_imu_sample_scheduler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/imu_pkg.sv
// Shared types and constants for the IMU sample scheduler.
// State encoding, default widths and counter step helpers.
package imu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADC_REQ,
    ADC_WAIT,
    MAG_REQ,
    MAG_WAIT,
    LATCH
  } state_t;

  localparam int ADC_W_DEF = 12;
  localparam int MAG_W_DEF = 16;

  localparam logic [7:0]  OVR_MAX  = 8'hFF;
  localparam logic [7:0]  OVR_STEP = 8'd1;
  localparam logic [15:0] CNT_STEP = 16'd1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == OVR_MAX) ? v : v + OVR_STEP;
  endfunction

endpackage

// File: rtl/imu_period_timer.sv
// Free-running sample period counter with enable.
// Holds at zero while disabled, so the first tick lands a full period later.
module imu_period_timer #(
  parameter int PERIOD = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + ONE;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/imu_sample_scheduler.sv
// Per-period ADC sweep then magnetometer read, latched into one snapshot.
// Tracks late sensors with sticky timeouts and counts ticks dropped while busy.
module imu_sample_scheduler
  import imu_pkg::*;
#(
  parameter int PERIOD  = 50000,
  parameter int TIMEOUT = 20000,
  parameter int ADC_W   = ADC_W_DEF,
  parameter int MAG_W   = MAG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             adc_start,
  input  logic             adc_done,
  input  logic [ADC_W-1:0] adc_depth,
  input  logic [ADC_W-1:0] adc_gyro_x,
  input  logic [ADC_W-1:0] adc_gyro_y,
  input  logic [ADC_W-1:0] adc_gyro_z,
  output logic             mag_start,
  input  logic             mag_done,
  input  logic [MAG_W-1:0] mag_x,
  input  logic [MAG_W-1:0] mag_y,
  input  logic [MAG_W-1:0] mag_z,
  output logic [ADC_W-1:0] snap_depth,
  output logic [ADC_W-1:0] snap_gyro_x,
  output logic [ADC_W-1:0] snap_gyro_y,
  output logic [ADC_W-1:0] snap_gyro_z,
  output logic [MAG_W-1:0] snap_mag_x,
  output logic [MAG_W-1:0] snap_mag_y,
  output logic [MAG_W-1:0] snap_mag_z,
  output logic             sample_valid,
  output logic [15:0]      sample_count,
  output logic [7:0]       overrun_count,
  output logic             adc_timeout,
  output logic             mag_timeout,
  output logic [1:0]       stale,
  input  logic             clear_status
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] W_ONE  = WW'(1);

  state_t state, next;
  logic tick;
  logic [WW-1:0] wcnt;
  logic wait_end, adc_cap, adc_to_ev, mag_fin, mag_to_ev, drop;

  logic [ADC_W-1:0] hold_depth, hold_gx, hold_gy, hold_gz;
  logic hold_stale;

  imu_period_timer #(.PERIOD(PERIOD)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  assign wait_end  = (wcnt == W_LAST);
  assign adc_cap   = (state == ADC_WAIT) && adc_done;
  assign adc_to_ev = (state == ADC_WAIT) && !adc_done && wait_end;
  assign mag_fin   = (state == MAG_WAIT) && (mag_done || wait_end);
  assign mag_to_ev = (state == MAG_WAIT) && !mag_done && wait_end;
  assign drop      = tick && (state != IDLE);

  assign sample_valid = (state == LATCH);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next      = state;
    adc_start = 1'b0;
    mag_start = 1'b0;
    unique case (state)
      IDLE:     if (tick) next = ADC_REQ;
      ADC_REQ: begin
        adc_start = 1'b1;
        next      = ADC_WAIT;
      end
      ADC_WAIT: if (adc_done || wait_end) next = MAG_REQ;
      MAG_REQ: begin
        mag_start = 1'b1;
        next      = MAG_WAIT;
      end
      MAG_WAIT: if (mag_done || wait_end) next = LATCH;
      LATCH:    next = IDLE;
      default:  next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt <= '0;
    end else if (state == ADC_REQ || state == MAG_REQ) begin
      wcnt <= '0;
    end else if (state == ADC_WAIT || state == MAG_WAIT) begin
      wcnt <= wcnt + W_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_depth <= '0;
      hold_gx    <= '0;
      hold_gy    <= '0;
      hold_gz    <= '0;
      hold_stale <= 1'b0;
    end else if (adc_cap) begin
      hold_depth <= adc_depth;
      hold_gx    <= adc_gyro_x;
      hold_gy    <= adc_gyro_y;
      hold_gz    <= adc_gyro_z;
      hold_stale <= 1'b0;
    end else if (adc_to_ev) begin
      hold_stale <= 1'b1;
    end
  end

  // Snapshot loads on the MAG_WAIT exit edge so it is visible during LATCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_depth   <= '0;
      snap_gyro_x  <= '0;
      snap_gyro_y  <= '0;
      snap_gyro_z  <= '0;
      snap_mag_x   <= '0;
      snap_mag_y   <= '0;
      snap_mag_z   <= '0;
      stale        <= '0;
      sample_count <= '0;
    end else if (mag_fin) begin
      snap_depth   <= hold_depth;
      snap_gyro_x  <= hold_gx;
      snap_gyro_y  <= hold_gy;
      snap_gyro_z  <= hold_gz;
      if (mag_done) begin
        snap_mag_x <= mag_x;
        snap_mag_y <= mag_y;
        snap_mag_z <= mag_z;
      end
      stale        <= {!mag_done, hold_stale};
      sample_count <= sample_count + CNT_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      adc_timeout   <= 1'b0;
      mag_timeout   <= 1'b0;
      overrun_count <= '0;
    end else begin
      if (adc_to_ev)         adc_timeout <= 1'b1;
      else if (clear_status) adc_timeout <= 1'b0;
      if (mag_to_ev)         mag_timeout <= 1'b1;
      else if (clear_status) mag_timeout <= 1'b0;
      if (drop)
        overrun_count <= clear_status ? OVR_STEP : sat_inc(overrun_count);
      else if (clear_status)
        overrun_count <= '0;
    end
  end

endmodule

// File: tb/tb_imu_sample_scheduler.sv
// Randomized bench for imu_sample_scheduler.
// Reference model works on a per-transaction timeline of scheduled cycles.
module tb_imu_sample_scheduler;

  localparam int P  = 20;
  localparam int TO = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, enable = 1'b0, clear_status = 1'b0;
  logic adc_done = 1'b0, mag_done = 1'b0;
  logic [11:0] adc_depth = '0, adc_gyro_x = '0, adc_gyro_y = '0, adc_gyro_z = '0;
  logic [15:0] mag_x = '0, mag_y = '0, mag_z = '0;
  logic adc_start, mag_start, sample_valid, adc_timeout, mag_timeout;
  logic [11:0] snap_depth, snap_gyro_x, snap_gyro_y, snap_gyro_z;
  logic [15:0] snap_mag_x, snap_mag_y, snap_mag_z, sample_count;
  logic [7:0] overrun_count;
  logic [1:0] stale;

  imu_sample_scheduler #(.PERIOD(P), .TIMEOUT(TO), .ADC_W(12), .MAG_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .adc_start(adc_start), .adc_done(adc_done),
    .adc_depth(adc_depth), .adc_gyro_x(adc_gyro_x),
    .adc_gyro_y(adc_gyro_y), .adc_gyro_z(adc_gyro_z),
    .mag_start(mag_start), .mag_done(mag_done),
    .mag_x(mag_x), .mag_y(mag_y), .mag_z(mag_z),
    .snap_depth(snap_depth), .snap_gyro_x(snap_gyro_x),
    .snap_gyro_y(snap_gyro_y), .snap_gyro_z(snap_gyro_z),
    .snap_mag_x(snap_mag_x), .snap_mag_y(snap_mag_y), .snap_mag_z(snap_mag_z),
    .sample_valid(sample_valid), .sample_count(sample_count),
    .overrun_count(overrun_count), .adc_timeout(adc_timeout),
    .mag_timeout(mag_timeout), .stale(stale), .clear_status(clear_status)
  );

  int errors = 0, checks = 0;
  int cyc = 0, run = 0, phase = 0, ph_cyc = 0;

  int t_as, t_ra, t_ms, t_rm, t_vld, t_free, p_a, p_m, stray_m;
  bit cap_a, cap_m, h_st, m_ato, m_mto;
  bit rst_done = 0, coinc_done = 0, expect_one = 0, chk_sat = 0;
  logic [11:0] h_adc [4];
  logic [11:0] m_adc [4];
  logic [15:0] m_mag [3];
  logic [1:0]  m_stale;
  logic [15:0] m_sc;
  logic [7:0]  m_ovr;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    t_as = -100; t_ra = -100; t_ms = -100; t_rm = -100;
    t_vld = -100; t_free = -100; p_a = -100; p_m = -100;
    run = 0; h_st = 0; m_ato = 0; m_mto = 0;
    m_stale = '0; m_sc = '0; m_ovr = '0;
    for (int i = 0; i < 4; i++) begin h_adc[i] = '0; m_adc[i] = '0; end
    for (int i = 0; i < 3; i++) m_mag[i] = '0;
  endtask

  // 0 means the done pulse never comes; values above TO arrive late.
  function automatic int pick_delay(input bit is_mag);
    int r;
    case (phase)
      0: return 1;
      1, 4: return is_mag ? 0 : 1;
      2: return TO;
      3: begin
        r = int'($urandom % 8);
        if (r == 0) return 0;
        if (r == 1) return TO;
        if (r == 2) return TO + 1 + int'($urandom % 2);
        return 1 + int'($urandom % TO);
      end
      default: return 0;
    endcase
  endfunction

  task automatic step();
    bit tick, drop, ato_ev, mto_ev;
    int da, dm;
    @(negedge clk);
    check("adc_start", 32'(adc_start), 32'(cyc == t_as));
    check("mag_start", 32'(mag_start), 32'(cyc == t_ms));
    check("sample_valid", 32'(sample_valid), 32'(cyc == t_vld));
    check("sample_count", 32'(sample_count), 32'(m_sc));
    check("overrun_count", 32'(overrun_count), 32'(m_ovr));
    check("adc_timeout", 32'(adc_timeout), 32'(m_ato));
    check("mag_timeout", 32'(mag_timeout), 32'(m_mto));
    check("stale", 32'(stale), 32'(m_stale));
    check("snap_depth", 32'(snap_depth), 32'(m_adc[0]));
    check("snap_gyro_x", 32'(snap_gyro_x), 32'(m_adc[1]));
    check("snap_gyro_y", 32'(snap_gyro_y), 32'(m_adc[2]));
    check("snap_gyro_z", 32'(snap_gyro_z), 32'(m_adc[3]));
    check("snap_mag_x", 32'(snap_mag_x), 32'(m_mag[0]));
    check("snap_mag_y", 32'(snap_mag_y), 32'(m_mag[1]));
    check("snap_mag_z", 32'(snap_mag_z), 32'(m_mag[2]));
    if (chk_sat) begin
      check("ovr_saturated", 32'(overrun_count), 32'hFF);
      chk_sat = 0;
    end
    if (expect_one) begin
      check("ovr_clear_vs_drop", 32'(overrun_count), 32'd1);
      expect_one = 0;
    end

    reset = 1'b0; enable = 1'b1; clear_status = 1'b0;
    adc_done = (cyc == p_a);
    mag_done = (cyc == p_m) || (cyc == stray_m);
    adc_depth  = 12'($urandom); adc_gyro_x = 12'($urandom);
    adc_gyro_y = 12'($urandom); adc_gyro_z = 12'($urandom);
    mag_x = 16'($urandom); mag_y = 16'($urandom); mag_z = 16'($urandom);
    case (phase)
      0: begin adc_depth = 12'h123; mag_x = 16'h8001; end
      2: clear_status = (ph_cyc == 0);
      3: begin
        enable = ($urandom % 32) != 0;
        clear_status = ($urandom % 40) == 0;
        if (cyc >= t_free) begin
          adc_done = adc_done | (($urandom % 16) == 0);
          mag_done = mag_done | (($urandom % 16) == 0);
        end
      end
      4: if (!rst_done && cyc == t_ms + 5 && cyc < t_rm) begin
        reset = 1'b1; rst_done = 1; stray_m = cyc + 1;
      end
      6: clear_status = (ph_cyc == 0);
      default: ;
    endcase
    tick = enable && !reset && (run % P == P - 1);
    drop = tick && (cyc < t_free);
    if (phase == 6 && drop && !coinc_done) begin
      clear_status = 1'b1; coinc_done = 1; expect_one = 1;
    end

    if (reset) begin
      model_reset();
    end else begin
      ato_ev = 0; mto_ev = 0;
      run = enable ? run + 1 : 0;
      if (cyc == t_ra) begin
        if (cap_a) begin
          h_adc[0] = adc_depth;  h_adc[1] = adc_gyro_x;
          h_adc[2] = adc_gyro_y; h_adc[3] = adc_gyro_z;
          h_st = 0;
        end else begin
          h_st = 1; ato_ev = 1;
        end
      end
      if (cyc == t_rm) begin
        for (int i = 0; i < 4; i++) m_adc[i] = h_adc[i];
        if (cap_m) begin
          m_mag[0] = mag_x; m_mag[1] = mag_y; m_mag[2] = mag_z;
        end else begin
          mto_ev = 1;
        end
        m_stale = {!cap_m, h_st};
        m_sc = m_sc + 16'd1;
      end
      if (tick && !drop) begin
        da = pick_delay(0); dm = pick_delay(1);
        cap_a = (da != 0) && (da <= TO);
        cap_m = (dm != 0) && (dm <= TO);
        t_as = cyc + 1;
        t_ra = t_as + (cap_a ? da : TO);
        p_a = (da != 0) ? t_as + da : -100;
        t_ms = t_ra + 1;
        t_rm = t_ms + (cap_m ? dm : TO);
        p_m = (dm != 0) ? t_ms + dm : -100;
        t_vld = t_rm + 1;
        t_free = t_rm + 2;
      end
      if (drop)
        m_ovr = clear_status ? 8'd1 : ((m_ovr == 8'hFF) ? 8'hFF : m_ovr + 8'd1);
      else if (clear_status)
        m_ovr = '0;
      if (ato_ev) m_ato = 1; else if (clear_status) m_ato = 0;
      if (mto_ev) m_mto = 1; else if (clear_status) m_mto = 0;
    end
    cyc++;
  endtask

  task automatic run_phase(input int ph, input int n);
    phase = ph;
    ph_cyc = 0;
    repeat (n) begin
      step();
      ph_cyc++;
    end
  endtask

  initial begin
    model_reset();
    stray_m = -100;
    cap_a = 0; cap_m = 0;
    repeat (3) @(negedge clk);
    run_phase(0, 200);
    run_phase(1, 150);
    run_phase(2, 150);
    run_phase(3, 3000);
    run_phase(4, 120);
    run_phase(5, 9000);
    chk_sat = 1;
    run_phase(6, 300);
    run_phase(0, 100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
